// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, idle level and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // XOR of the low nbits of data, inverted for odd parity; TX uses it to generate, RX to check.
    function automatic logic parity_calc(input logic [8:0] data, input int unsigned nbits,
                                         input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx_line synchroniser, falling-edge detect and 3-sample majority voter
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OS = 16,
    localparam int TW = $clog2(OS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          os_tick,
    input  logic          rx_line,
    input  logic [TW-1:0] tcnt,
    output logic          line_sync,
    output logic          fall,
    output logic          bit_val
);

    localparam logic [TW-1:0] T_S0 = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] T_S1 = TW'(OS / 2);

    logic r_meta, r_sync, r_prev, r_fall_pend, r_s0, r_s1;
    logic w_edge;

    assign w_edge = r_prev & ~r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta      <= UART_IDLE_LEVEL;
            r_sync      <= UART_IDLE_LEVEL;
            r_prev      <= UART_IDLE_LEVEL;
            r_fall_pend <= 1'b0;
            r_s0        <= UART_IDLE_LEVEL;
            r_s1        <= UART_IDLE_LEVEL;
        end else begin
            r_meta <= rx_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
            // An edge seen between ticks is held so the tick-paced FSM cannot miss it.
            if (os_tick)
                r_fall_pend <= 1'b0;
            else if (w_edge)
                r_fall_pend <= 1'b1;
            if (os_tick && tcnt == T_S0) r_s0 <= r_sync;
            if (os_tick && tcnt == T_S1) r_s1 <= r_sync;
        end
    end

    assign line_sync = r_sync;
    assign fall      = w_edge | r_fall_pend;
    // Third sample is the live synchronised line at the resolving tick.
    assign bit_val   = (r_s0 & r_s1) | (r_s0 & r_sync) | (r_s1 & r_sync);

endmodule

// File: rtl/uart_rx_osn.sv
// rtl/uart_rx_osn.sv - oversampling UART receiver; parity stage enabled by UART_RX_PARITY_EN
module uart_rx_osn
    import uart_pkg::*;
#(
    parameter int OS         = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int TW = $clog2(OS);
    localparam logic [TW-1:0] T_VOTE  = TW'(OS / 2 + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OS - 1);
    localparam logic [3:0]    B_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_SLAST = 4'(STOP_BITS - 1);

    rx_state_t            r_state;
    logic [TW-1:0]        r_tcnt;
    logic [3:0]           r_bcnt;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_valid, r_fe, r_pe, r_busy, r_armed, r_stop_err;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
`endif
    logic w_line_sync, w_fall, w_bit, w_vote, w_last;

    uart_rx_sampler #(.OS(OS)) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .os_tick   (os_tick),
        .rx_line   (rx_line),
        .tcnt      (r_tcnt),
        .line_sync (w_line_sync),
        .fall      (w_fall),
        .bit_val   (w_bit)
    );

    assign w_vote = (r_tcnt == T_VOTE);
    assign w_last = (r_tcnt == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tcnt     <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_busy     <= 1'b0;
            r_armed    <= 1'b1;
            r_stop_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (os_tick) begin
                if (r_state != IDLE) r_tcnt <= w_last ? '0 : r_tcnt + 1'b1;
                case (r_state)
                    IDLE: begin
                        // Re-arm only once the line has recovered, so a held break yields one frame.
                        if (w_line_sync == UART_IDLE_LEVEL) r_armed <= 1'b1;
                        if (w_fall && r_armed) begin
                            r_state    <= START;
                            r_tcnt     <= '0;
                            r_busy     <= 1'b1;
                            r_stop_err <= 1'b0;
                        end
                    end
                    START: begin
                        if (w_vote && w_bit) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_last) begin
                            r_state <= DATA;
                            r_bcnt  <= '0;
                        end
                    end
                    DATA: begin
                        if (w_vote) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        if (w_last) begin
                            if (r_bcnt == B_DLAST) begin
                                r_bcnt <= '0;
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_bcnt <= r_bcnt + 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (w_vote) r_par <= w_bit;
                        if (w_last) r_state <= STOP;
                    end
`endif
                    STOP: begin
                        if (w_vote) begin
                            if (r_bcnt == B_SLAST) begin
                                r_valid <= 1'b1;
                                r_data  <= r_shift;
                                r_fe    <= r_stop_err | ~w_bit;
                                r_armed <= ~(r_stop_err | ~w_bit);
`ifdef UART_RX_PARITY_EN
                                r_pe    <= parity_calc(9'(r_shift), DATA_BITS, PARITY_ODD[0]) ^ r_par;
`endif
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_stop_err <= r_stop_err | ~w_bit;
                            end
                        end
                        if (w_last) r_bcnt <= r_bcnt + 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out      = r_data;
    assign valid         = r_valid;
    assign framing_error = r_fe;
    assign parity_error  = r_pe;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_osn.sv
// tb/tb_uart_rx_osn.sv - directed bench for uart_rx_osn (default and OS8/7-bit/2-stop instances)
`timescale 1ns/1ps
module tb_uart_rx_osn;

`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, os_tick = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic valid0, fe0, pe0, busy0, valid1, fe1, pe1, busy1;

    int n_checks = 0, n_fail = 0;
    int div = 1, tick_cnt = 0, cyc = 0;
    int n0 = 0, n1 = 0;
    int cap0_data[32], cap0_fe[32], cap0_pe[32];
    int cap1_data[32], cap1_fe[32], cap1_cyc[32];

    uart_rx_osn u_dut0 (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_line(rx0),
        .data_out(data0), .valid(valid0), .framing_error(fe0),
        .parity_error(pe0), .busy(busy0)
    );

    uart_rx_osn #(.OS(8), .DATA_BITS(7), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_line(rx1),
        .data_out(data1), .valid(valid1), .framing_error(fe1),
        .parity_error(pe1), .busy(busy1)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tick_cnt >= div - 1) begin
            tick_cnt = 0;
            os_tick  = 1'b1;
        end else begin
            tick_cnt++;
            os_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (valid0 && n0 < 32) begin
            cap0_data[n0] = int'(data0);
            cap0_fe[n0]   = int'(fe0);
            cap0_pe[n0]   = int'(pe0);
            n0++;
        end
        if (valid1 && n1 < 32) begin
            cap1_data[n1] = int'(data1);
            cap1_fe[n1]   = int'(fe1);
            cap1_cyc[n1]  = cyc;
            n1++;
        end
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int which, input logic [8:0] d, input int nbits, input int nstop,
                        input int os, input logic par_flip, input logic stop_lvl);
        int bt;
        logic p;
        bt = os * div;
        p  = par_flip;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        drive(which, 1'b0);
        wait_clk(bt);
        for (int i = 0; i < nbits; i++) begin
            drive(which, d[i]);
            wait_clk(bt);
        end
        if (P == 1) begin
            drive(which, p);
            wait_clk(bt);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(which, stop_lvl);
            wait_clk(bt);
        end
    endtask

    initial begin
        int base, start_cyc, lat, lat_f;

        wait_clk(3);
        check_eq("rst_data_out", int'(data0), 0);
        check_eq("rst_valid", int'(valid0), 0);
        check_eq("rst_framing_error", int'(fe0), 0);
        check_eq("rst_parity_error", int'(pe0), 0);
        check_eq("rst_busy", int'(busy0), 0);
        rst_n = 1'b1;
        wait_clk(4);

        // Default build, ticks every 3 clk, back-to-back frames
        div = 3;
        wait_clk(6);
        send(0, 9'h0B3, 8, 1, 16, 1'b0, 1'b1);
        send(0, 9'h05A, 8, 1, 16, 1'b0, 1'b1);
        wait_clk(16 * 3 * 2);
        check_eq("b2b_count", n0, 2);
        check_eq("b2b_data0", cap0_data[0], 'hB3);
        check_eq("b2b_fe0", cap0_fe[0], 0);
        check_eq("b2b_pe0", cap0_pe[0], 0);
        check_eq("b2b_data1", cap0_data[1], 'h5A);
        check_eq("b2b_fe1", cap0_fe[1], 0);

        // OS=8, 7 data bits, 2 stops, one tick per clk, latency window
        div = 1;
        wait_clk(4);
        start_cyc = cyc;
        send(1, 9'h041, 7, 2, 8, 1'b0, 1'b1);
        wait_clk(16);
        lat_f = (1 + 7 + P + 2 - 1) * 8 + 4 + 1;
        lat   = (n1 > 0) ? cap1_cyc[0] - start_cyc : -100;
        check_eq("os8_count", n1, 1);
        check_eq("os8_data", cap1_data[0], 'h41);
        check_eq("os8_fe", cap1_fe[0], 0);
        check_eq("os8_latency_window", int'(lat >= lat_f - 1 && lat <= lat_f + 6), 1);
        check_eq("os8_busy_idle", int'(busy1), 0);

        // Three-tick low glitch must abort at the START vote
        div = 3;
        wait_clk(6);
        base = n0;
        rx0 = 1'b0;
        wait_clk(9);
        rx0 = 1'b1;
        wait_clk(2);
        check_eq("glitch_busy_in_start", int'(busy0), 1);
        wait_clk(40 * 3);
        check_eq("glitch_busy_cleared", int'(busy0), 0);
        check_eq("glitch_no_valid", n0 - base, 0);

        // Framing error on 0x00 followed by a held break
        div = 1;
        wait_clk(4);
        base = n0;
        send(0, 9'h000, 8, 1, 16, 1'b0, 1'b0);
        wait_clk(3 * (10 + P) * 16);
        check_eq("break_one_valid", n0 - base, 1);
        check_eq("break_data", cap0_data[base], 0);
        check_eq("break_fe", cap0_fe[base], 1);
        check_eq("break_busy", int'(busy0), 0);
        rx0 = 1'b1;
        wait_clk(32);
        check_eq("break_no_valid_on_release", n0 - base, 1);
        send(0, 9'h096, 8, 1, 16, 1'b0, 1'b1);
        wait_clk(32);
        check_eq("rearm_count", n0 - base, 2);
        check_eq("rearm_data", cap0_data[base + 1], 'h96);
        check_eq("rearm_fe_cleared", cap0_fe[base + 1], 0);
        check_eq("rearm_data_out_held", int'(data0), 'h96);

`ifdef UART_RX_PARITY_EN
        base = n0;
        send(0, 9'h007, 8, 1, 16, 1'b0, 1'b1);
        wait_clk(32);
        send(0, 9'h007, 8, 1, 16, 1'b1, 1'b1);
        wait_clk(32);
        check_eq("par_count", n0 - base, 2);
        check_eq("par_good", cap0_pe[base], 0);
        check_eq("par_good_data", cap0_data[base], 'h07);
        check_eq("par_bad", cap0_pe[base + 1], 1);
`endif

        // Asynchronous reset in the middle of DATA
        div = 3;
        wait_clk(6);
        rx0 = 1'b0;
        wait_clk(48);
        rx0 = 1'b1;
        wait_clk(48);
        rx0 = 1'b1;
        wait_clk(48);
        rx0 = 1'b0;
        wait_clk(20);
        check_eq("midrst_busy_before", int'(busy0), 1);
        rst_n = 1'b0;
        rx0 = 1'b1;
        #1;
        check_eq("midrst_data_out", int'(data0), 0);
        check_eq("midrst_valid", int'(valid0), 0);
        check_eq("midrst_fe", int'(fe0), 0);
        check_eq("midrst_pe", int'(pe0), 0);
        check_eq("midrst_busy", int'(busy0), 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(48);
        base = n0;
        send(0, 9'h0C3, 8, 1, 16, 1'b0, 1'b1);
        wait_clk(16 * 3 * 2);
        check_eq("post_rst_count", n0 - base, 1);
        check_eq("post_rst_data", cap0_data[base], 'hC3);
        check_eq("post_rst_fe", cap0_fe[base], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_osn.md
# uart_rx_osn

Parametrised oversampling UART receiver, the successor to the fixed 16x receiver. It is driven by the shared oversample tick from `baud_gen` at BAUD×OS. It decodes LSB-first asynchronous frames with configurable data width, stop-bit count, oversample ratio and optional parity. Each bit is recovered by a 3-sample majority vote. Per-frame status pulses go to the downstream consumer (FIFO or register interface).

## Interface
Parameters:
- `OS`, 16: oversample ratio, ticks per bit. Even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Only meaningful when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `os_tick`  in  1  single-cycle oversample enable.
- `rx_line`  in  1  asynchronous serial input, idle high.
- `data_out`  out  DATA_BITS  last received word. Held until the next frame completes.
- `valid`  out  1  one-cycle pulse: frame complete.
- `framing_error`  out  1  qualified by `valid`: a stop bit was sampled low.
- `parity_error`  out  1  qualified by `valid`: parity mismatch. Tied 0 when parity is compiled out.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx_line` passes through a 2-flop synchroniser before any use. Its reset value is 1.
- **Majority vote:** samples are taken at tick counts OS/2−1, OS/2 and OS/2+1 within a bit. The bit value is the majority of the three and is resolved at OS/2+1.
- **State machine** (tick counter `tcnt`, width $clog2(OS); bit counter `bcnt`; all advance only on `os_tick`):
  - IDLE → START: on a synchronised high→low edge while `armed`=1. `tcnt` is cleared on entry.
  - START: the voted bit at OS/2+1 decides the path.
    - Voted 1 (glitch): return to IDLE, no output.
    - Voted 0: continue counting. At `tcnt`=OS−1, go to DATA with `bcnt`=0.
  - DATA: shift the voted bit into the MSB of the shift register (LSB-first).
    - At `tcnt`=OS−1 with `bcnt`=DATA_BITS−1, go to PARITY if compiled in, otherwise STOP.
  - PARITY: capture the voted bit, then go to STOP.
  - STOP: check the voted bit for each of STOP_BITS bits.
    - On the final stop bit's vote point (OS/2+1), go to IDLE. The check does not wait for the end of the bit, so back-to-back frames are accepted.
- **Error rules:**
  - Any stop bit voting 0 sets `framing_error`. Data is still delivered.
  - After a framing error, `armed` clears. It re-sets only after the synchronised line has been seen high in IDLE, so a break condition is not decoded as repeated 0x00 frames.
- **Parity:** `parity_error` = (XOR of data bits ^ parity bit ^ PARITY_ODD) ≠ 0.

## Timing
- **Reset values:** `data_out`=0, `valid`=0, `framing_error`=0, `parity_error`=0, `busy`=0, state=IDLE, `armed`=1.
- **Output update:** `valid`, `data_out` and the error flags all update on the same `clk` edge. That edge is the one on which the final stop bit's vote resolves.
  - `valid` is high for exactly one `clk` cycle.
  - The error flags are held until the next `valid`.
- **Latency:** from the falling edge of the start bit to `valid`, (1 + DATA_BITS + P + STOP_BITS − 1)·OS + OS/2 + 1 ticks, plus 2–3 `clk` of synchroniser and edge delay. P = 1 when parity is enabled, else 0.
- **Non-tick cycles:** `os_tick` low holds all state. The synchroniser and edge detector still run every `clk`.
- **Reset mid-frame:** abort immediately and return to IDLE. No `valid` is produced.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists.
  - `parity_error` is computed.
  - The frame has one extra bit.
- Not defined:
  - The PARITY state and its logic are absent.
  - `parity_error` is constant 0.
  - The `PARITY_ODD` parameter is ignored.

## Structure
- `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the `UART_IDLE_LEVEL` constant;
  - the `parity_calc` function, shared with the future parametrised TX.
- Sub-module `uart_rx_sampler`: synchroniser, falling-edge detect and 3-sample majority voter. Parametrised by `OS`. Takes `tcnt` and `os_tick` in; drives `line_sync`, `fall` and `bit_val` out.

## Test plan
All scenarios: 50 MHz `clk`, `baud_gen` at 115200×OS, loopback from `uart_tx`.
- Default parameters, send 0xB3 → `valid` pulse, `data_out`=0xB3, `framing_error`=0. A second frame 0x5A sent back-to-back → second `valid` with 0x5A.
- OS=8, DATA_BITS=7, STOP_BITS=2, frame 0x41 → `data_out`=7'h41, no errors. Latency matches the formula within ±3 `clk`.
- Low glitch of 3 os_ticks on an idle line → no `valid`, `busy` returns to 0 after the START vote point.
- Stop bit forced low on frame 0x00, then line held low for 3 frame times → exactly one `valid` with `framing_error`=1, no further `valid` until the line returns high.
- `UART_RX_PARITY_EN` defined, `PARITY_ODD`=0, frame 0x07 with parity bit 1 → `parity_error`=0. Parity bit flipped → `parity_error`=1.
- `rst_n` pulsed low mid-DATA → all outputs return to their reset values asynchronously. The next clean frame 0xC3 is received correctly.
